// File: rtl/uart_hamming_receiver.sv
// UART 8N1 receiver with Hamming(7,4) single-error correction of byte bits [6:0].
// Latency: data_valid pulses 1 cycle after the mid-stop-bit sample; frame_err pulses on that sample edge.
// Backpressure: none; results are one-cycle strobes, and data_out/corrected/code_out hold until the next decode.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset (priority over all other events)
//   rx         - asynchronous serial line, idle high
//   data_out   - corrected 4-bit payload d3..d0
//   data_valid - one-cycle strobe qualifying data_out / corrected / code_out
//   corrected  - a nonzero syndrome was seen and one bit was flipped back
//   frame_err  - one-cycle strobe, stop bit sampled low (byte discarded)
//   code_out   - raw received codeword before correction
//   busy       - high whenever the receiver is not in IDLE
//   err_count  - (only with RX_ERR_CNT_EN defined) saturating count of framing
//                errors plus corrected frames
//
// Optional feature macro: RX_ERR_CNT_EN
module uart_hamming_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       corrected,
    output logic       frame_err,
    output logic [6:0] code_out,
    output logic       busy
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP,
        DECODE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rx_meta;
    logic            rx_s;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [6:0]      code_reg;
    logic            timer_clr;
    logic            sample_en;
    logic            dv_next;
    logic            fe_next;
    logic [2:0]      syndrome;
    logic [6:0]      code_fixed;
    logic [3:0]      dec_data;
    logic            dec_corr;

    // Two-flop synchroniser; resets to the idle level so nothing looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        sample_en  = 1'b0;
        dv_next    = 1'b0;
        fe_next    = 1'b0;
        case (state)
            // Line may be held low (reset, broken frame); wait for idle before arming.
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    timer_clr  = 1'b1;
                end
            end
            START: begin
                if (timer == T_HALF) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        timer_clr  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (timer == T_FULL) begin
                    sample_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            // Leaving at mid stop bit keeps half a bit of slack for a zero-gap next frame.
            STOP: begin
                if (timer == T_FULL) begin
                    if (rx_s) begin
                        state_next = DECODE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            DECODE: begin
                dv_next    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = WAIT_IDLE;
            end
        endcase
    end

    // Syndrome value equals the 1-based position of the flipped bit.
    always_comb begin
        syndrome[0] = code_reg[0] ^ code_reg[2] ^ code_reg[4] ^ code_reg[6];
        syndrome[1] = code_reg[1] ^ code_reg[2] ^ code_reg[5] ^ code_reg[6];
        syndrome[2] = code_reg[3] ^ code_reg[4] ^ code_reg[5] ^ code_reg[6];
        code_fixed  = code_reg;
        dec_corr    = 1'b0;
        if (syndrome != 3'd0) begin
            code_fixed[syndrome - 3'd1] = ~code_reg[syndrome - 3'd1];
            dec_corr                    = 1'b1;
        end
        dec_data = {code_fixed[6], code_fixed[5], code_fixed[4], code_fixed[2]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            bit_idx    <= '0;
            code_reg   <= '0;
            data_out   <= '0;
            corrected  <= 1'b0;
            code_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (timer_clr || timer == T_FULL) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if (sample_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            // Byte bit 7 is padding and is never stored.
            if (sample_en && bit_idx != 3'd7) begin
                code_reg[bit_idx] <= rx_s;
            end

            data_valid <= dv_next;
            frame_err  <= fe_next;
            // Registered from the next state so busy tracks state yet reads 0 during reset.
            busy       <= (state_next != IDLE);

            if (dv_next) begin
                data_out  <= dec_data;
                corrected <= dec_corr;
                code_out  <= code_reg;
            end
        end
    end

`ifdef RX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if ((fe_next || (dv_next && dec_corr)) && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_hamming_receiver.sv
// Self-checking bench for uart_hamming_receiver: scoreboard of expected decodes plus per-scenario checks.
// Latency: expected decodes are popped when data_valid is seen on the falling edge.
// Backpressure: none; serial stimulus is driven on falling clock edges at CLKS_PER_BIT cycles per bit.
module tb_uart_hamming_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [3:0] data_out;
    logic       data_valid;
    logic       corrected;
    logic       frame_err;
    logic [6:0] code_out;
    logic       busy;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    uart_hamming_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .corrected  (corrected),
        .frame_err  (frame_err),
        .code_out   (code_out),
        .busy       (busy)
`ifdef RX_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    typedef struct {
        logic [3:0] data;
        logic       corr;
        logic [6:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   dv_cnt   = 0;
    int   fe_cnt   = 0;
    logic prev_dv  = 1'b0;
    logic prev_fe  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder straight from the parity equations.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    task automatic push_exp(input logic [3:0] d, input logic [6:0] code);
        exp_t e;
        e.data = d;
        e.code = code;
        e.corr = (code != encode(d));
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic v);
        @(negedge clk);
        rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(b[i]);
        hold(stop);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (prev_dv) begin
            n_checks++;
            if (data_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dv_width: data_valid=%b required 0 on cycle after pulse", data_valid);
            end
        end
        if (prev_fe) begin
            n_checks++;
            if (frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL fe_width: frame_err=%b required 0 on cycle after pulse", frame_err);
            end
        end
        if (data_valid === 1'b1) begin
            dv_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: data_out=%h corrected=%b code_out=%h, none expected",
                         data_out, corrected, code_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({data_out, corrected, code_out} !== {e.data, e.corr, e.code}) begin
                    n_fail++;
                    $display("FAIL decode: got data=%h corr=%b code=%h, required data=%h corr=%b code=%h",
                             data_out, corrected, code_out, e.data, e.corr, e.code);
                end
            end
        end
        if (frame_err === 1'b1) fe_cnt++;
        prev_dv = (data_valid === 1'b1);
        prev_fe = (frame_err === 1'b1);
    end

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({data_out, data_valid, corrected, frame_err, code_out, busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h dv=%b corr=%b fe=%b code=%h busy=%b, required all 0",
                     data_out, data_valid, corrected, frame_err, code_out, busy);
        end
`ifdef RX_ERR_CNT_EN
        n_checks++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_count: got %0d required 0", err_count);
        end
`endif
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_clean;
        int fe0;
        fe0 = fe_cnt;
        push_exp(4'hB, 7'h55);
        send_frame(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL clean_drain: %0d decodes outstanding, required 0", exp_q.size());
        end
        n_checks++;
        if (fe_cnt !== fe0) begin
            n_fail++;
            $display("FAIL clean_no_fe: frame_err pulses=%0d required 0", fe_cnt - fe0);
        end
        n_checks++;
        if (data_out !== 4'hB) begin
            n_fail++;
            $display("FAIL clean_hold: data_out=%h required b", data_out);
        end
    endtask

    task automatic test_padding;
        push_exp(4'hB, 7'h55);
        send_frame(8'hD5, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL padding_drain: %0d decodes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_single_error;
        logic [6:0] c;
        int         dv0;
        dv0 = dv_cnt;
        push_exp(4'hB, 7'h45);
        send_frame(8'h45, 1'b1);
        for (int i = 0; i < 7; i++) begin
            c = encode(4'hF) ^ (7'd1 << i);
            push_exp(4'hF, c);
            send_frame({1'b0, c}, 1'b1);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (dv_cnt - dv0 !== 8) begin
            n_fail++;
            $display("FAIL single_err_count: data_valid pulses=%0d required 8", dv_cnt - dv0);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL single_err_drain: %0d decodes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int dv0;
        dv0 = dv_cnt;
        push_exp(4'h0, 7'h00);
        push_exp(4'hF, 7'h7F);
        send_frame(8'h00, 1'b1);
        send_frame(8'h7F, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (dv_cnt - dv0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: data_valid pulses=%0d required 2", dv_cnt - dv0);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d decodes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_frame_err_glitch;
        int dv0;
        int fe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fe_wait_busy: busy=%b required 1 while line held low", busy);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (fe_cnt - fe0 !== 1) begin
            n_fail++;
            $display("FAIL fe_pulse: frame_err pulses=%0d required 1", fe_cnt - fe0);
        end
        n_checks++;
        if (dv_cnt !== dv0) begin
            n_fail++;
            $display("FAIL fe_no_dv: data_valid pulses=%0d required 0", dv_cnt - dv0);
        end
        n_checks++;
        if ({data_out, code_out} !== {4'hF, 7'h7F}) begin
            n_fail++;
            $display("FAIL fe_hold: data_out=%h code_out=%h required f 7f", data_out, code_out);
        end
        // Four-cycle glitch is shorter than half a bit and must not start a frame.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: busy=%b required 0", busy);
        end
        n_checks++;
        if (dv_cnt !== dv0 || fe_cnt - fe0 !== 1) begin
            n_fail++;
            $display("FAIL glitch_pulses: dv=%0d fe=%0d required 0 and 1", dv_cnt - dv0, fe_cnt - fe0);
        end
        push_exp(4'h0, 7'h00);
        send_frame(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL after_fe_drain: %0d decodes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        int         dv0;
        int         fe0;
        b = 8'h55;
        hold(1'b0);
        for (int i = 0; i < 3; i++) hold(b[i]);
        @(negedge clk);
        rx = b[3];
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({data_out, data_valid, corrected, frame_err, code_out, busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: data=%h dv=%b corr=%b fe=%b code=%h busy=%b, required all 0",
                     data_out, data_valid, corrected, frame_err, code_out, busy);
        end
        rst = 1'b0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        repeat (200) @(negedge clk);
        n_checks++;
        if (dv_cnt !== dv0 || fe_cnt !== fe0) begin
            n_fail++;
            $display("FAIL mid_reset_pulses: dv=%0d fe=%0d required 0 and 0", dv_cnt - dv0, fe_cnt - fe0);
        end
        push_exp(4'hF, 7'h7F);
        send_frame(8'h7F, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_drain: %0d decodes outstanding, required 0", exp_q.size());
        end
    endtask

`ifdef RX_ERR_CNT_EN
    task automatic test_err_count;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h55, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            push_exp(4'hB, 7'h45);
            send_frame(8'h45, 1'b1);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL err_count_3: got %0d required 3", err_count);
        end
        for (int i = 0; i < 300; i++) begin
            push_exp(4'hB, 7'h45);
            send_frame(8'h45, 1'b1);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL err_count_sat: got %0d required 255", err_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_clean();
        test_padding();
        test_single_error();
        test_back_to_back();
        test_frame_err_glitch();
        test_reset_mid_frame();
`ifdef RX_ERR_CNT_EN
        test_err_count();
`endif
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d decodes outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_hamming_receiver.md
Name: uart_hamming_receiver

Overview:
- Receive end of the UART + Hamming(7,4) link; mirror image of the existing encoder-plus-transmitter path.
- Deserialises 8N1 UART frames from an asynchronous rx pin and treats byte bits [6:0] as a Hamming(7,4) codeword.
- Corrects any single-bit error and presents the 4-bit payload with a one-cycle valid strobe and status flags.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Legal when ≥4 and even; must match the transmitter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data_out  out  4  decoded (corrected) payload d3..d0.
- data_valid  out  1  one-cycle pulse; data_out/corrected/code_out valid.
- corrected  out  1  nonzero syndrome, one bit flipped; qualified by data_valid.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- code_out  out  7  raw received codeword before correction (debug).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0. Synchroniser flops reset to 1. State resets to WAIT_IDLE.
- rx passes through a 2-flop synchroniser; rx_s = second flop. All sampling uses rx_s.
- Bit timer counts 0..CLKS_PER_BIT-1. A bit index counts 0..7.
- States:
  - WAIT_IDLE: stay until rx_s=1, then IDLE. Prevents a false start when the line is low out of reset or after a framing error.
  - IDLE: on rx_s=0 go to START and clear the timer.
  - START: at timer=CLKS_PER_BIT/2-1 (mid start bit):
    - rx_s=1 → glitch: return to IDLE, no flag.
    - else clear the timer and go to DATA.
  - DATA: at timer=CLKS_PER_BIT-1 (mid-bit), shift rx_s in LSB first. After bit index 7, go to STOP.
  - STOP: at mid stop bit:
    - rx_s=1 → DECODE.
    - rx_s=0 → pulse frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
  - DECODE: one cycle. Register data_out, corrected and code_out; pulse data_valid; go to IDLE.
- Latency: data_valid rises exactly 1 cycle after the mid-stop-bit sample edge.
- Returning to IDLE at mid stop bit leaves half a bit of margin, so back-to-back frames with zero idle gap are received.
- Codeword layout, position p = bit index + 1:
  - [0]=p1, [1]=p2, [2]=d0, [3]=p4, [4]=d1, [5]=d2, [6]=d3.
  - p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
- Syndrome s = {s4,s2,s1}:
  - s1 = XOR of bits 0,2,4,6.
  - s2 = XOR of bits 1,2,5,6.
  - s4 = XOR of bits 3,4,5,6.
  - s≠0 → invert bit s-1 before extracting data and set corrected=1.
  - s=0 → corrected=0.
- Byte bit 7 (padding) is ignored.
- Double-bit errors miscorrect silently; no detection is required.
- data_out and code_out hold their value until the next DECODE. Neither changes on frame_err.
- Reset mid-frame: abort immediately, produce no data_valid or frame_err pulse, go to WAIT_IDLE.
- rst has priority over every other event in the same cycle.

Optional Feature:
- Macro: RX_ERR_CNT_EN.
- Defined:
  - Adds output port err_count[7:0], reset 0.
  - Increments by 1 on each frame_err pulse and on each data_valid with corrected=1; saturates at 255.
  - Cleared only by rst.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Clean frame: byte 0x55 (data 4'hB), CLKS_PER_BIT=16 → one data_valid pulse, data_out=4'hB, corrected=0, code_out=7'h55, frame_err never high.
- Single-bit error: byte 0x45 (bit 4 flipped) → data_out=4'hB, corrected=1. Repeat flipping each of bits 0..6 of codeword 0x7F (data 4'hF) → data_out=4'hF, corrected=1 every time.
- Back-to-back: bytes 0x00 then 0x7F with no idle gap → two data_valid pulses, data_out=4'h0 then 4'hF, both with corrected=0.
- Framing error then glitch:
  - 0x55 frame with stop bit low → frame_err pulses once, no data_valid; receiver waits for rx high.
  - Then rx low for 4 cycles → no start and busy returns 0.
  - Then a valid 0x00 frame → data_out=4'h0.
- Reset mid-frame: assert rst during data bit 3 of 0x55 → busy=0 and all outputs 0 next cycle, no pulses; the following frame 0x7F decodes to 4'hF.
- With RX_ERR_CNT_EN: 1 framing error + 2 corrected frames → err_count=3. Then 300 corrected frames → err_count=255.
